// File: rtl/chunked_wide_adder.sv
// Multi-cycle carry-propagate adder: adds WIDTH-bit operands one CHUNK-bit slice per cycle.
// Optional subtract mode under CHUNKED_ADDER_SUB_EN (adds a 'sub' input sampled at accept).
module chunked_wide_adder #(
  parameter int unsigned WIDTH = 1024,
  parameter int unsigned CHUNK = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef CHUNKED_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int unsigned NCHUNK = WIDTH / CHUNK;
  localparam int unsigned CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam int unsigned SW     = CHUNK + 1;
  localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, work_q, work_d;
  logic [WIDTH-1:0] sum_d;
  logic             cout_d, in_ready_d, out_valid_d;
  logic [SW-1:0]    slice;
  logic [WIDTH-1:0] work_next;

  // Operands shift down one slice per RUN cycle, so the active slice is always at bit 0;
  // results shift in from the top and end up in place after NCHUNK cycles.
  always_comb begin
    slice     = SW'(a_q[CHUNK-1:0]) + SW'(b_q[CHUNK-1:0]) + SW'(carry_q);
    work_next = (work_q >> CHUNK) | (WIDTH'(slice[CHUNK-1:0]) << (WIDTH - CHUNK));
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    carry_d     = carry_q;
    a_d         = a_q;
    b_d         = b_q;
    work_d      = work_q;
    sum_d       = sum;
    cout_d      = cout;
    in_ready_d  = in_ready;
    out_valid_d = out_valid;
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready) begin
          a_d        = a;
          b_d        = b;
          carry_d    = cin;
`ifdef CHUNKED_ADDER_SUB_EN
          if (sub) begin
            b_d     = ~b;
            carry_d = 1'b1;
          end
`endif
          cnt_d      = '0;
          in_ready_d = 1'b0;
          state_d    = RUN;
        end
      end
      RUN: begin
        a_d     = a_q >> CHUNK;
        b_d     = b_q >> CHUNK;
        work_d  = work_next;
        carry_d = slice[CHUNK];
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          sum_d   = work_next;
          cout_d  = slice[CHUNK];
          state_d = DONE;
        end
      end
      DONE: begin
        out_valid_d = 1'b1;
        if (out_valid && out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d     = IDLE;
        in_ready_d  = 1'b1;
        out_valid_d = 1'b0;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      carry_q   <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      work_q    <= '0;
      sum       <= '0;
      cout      <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      carry_q   <= carry_d;
      a_q       <= a_d;
      b_q       <= b_d;
      work_q    <= work_d;
      sum       <= sum_d;
      cout      <= cout_d;
      in_ready  <= in_ready_d;
      out_valid <= out_valid_d;
    end
  end

endmodule
